// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, PC step and reset
// defaults.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        STALL = 2'b10
    } state_t;

    localparam logic [31:0] WORD_INC         = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch/jump targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter storage: a redirect load beats a sequential increment,
// which beats hold.
module instruction_fetch_unit_pc_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        incr,
    output logic [31:0] pc
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (incr) begin
            pc <= pc + WORD_INC;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: sequences instruction-memory reads from the PC and hands each
// captured word to decode over a valid/ready handshake with stall and redirect.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        pc_load,
    input  logic [31:0] pc_in,
    input  logic        if_ready,
    input  logic [31:0] D_In,
    output logic        im_cs,
    output logic        im_rd,
    output logic [31:0] Address,
    output logic [31:0] IR,
    output logic [31:0] IR_PC,
    output logic [31:0] PC_plus4,
    output logic        if_valid,
    output logic        align_err
);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        transfer;
    logic        ir_free;
    logic        capture;

    assign transfer = if_valid & if_ready;
    assign ir_free  = ~if_valid | transfer;

    instruction_fetch_unit_pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .load_value (word_align(pc_in)),
        .incr       (capture),
        .pc         (pc)
    );

    // Upper PC bits do not reach the memory, so the address wraps in 2^ADDR_BITS.
    assign Address  = {{(32 - ADDR_BITS){1'b0}}, pc[ADDR_BITS-1:2], 2'b00};
    assign PC_plus4 = IR_PC + WORD_INC;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        im_cs      = 1'b0;
        im_rd      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                im_cs = 1'b1;
                im_rd = 1'b1;
                if (!ir_free)  state_next = STALL;
                else if (!run) state_next = IDLE;
                else           capture    = 1'b1;
            end
            STALL: begin
                if (transfer) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
        // A redirect overrides whatever the current state decided.
        if (pc_load) begin
            capture    = 1'b0;
            state_next = run ? FETCH : IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            IR        <= '0;
            IR_PC     <= '0;
            if_valid  <= 1'b0;
            align_err <= 1'b0;
        end else begin
            state     <= state_next;
            align_err <= pc_load & (pc_in[1:0] != 2'b00);
            if (capture) begin
                IR       <= D_In;
                IR_PC    <= pc;
                if_valid <= 1'b1;
            end else if (pc_load || transfer) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the Enhanced MIPS processor. Holds the program counter, drives the read side of the 4096x8 big-endian instruction memory, and captures each 32-bit word into an instruction register. It presents the word to decode over a valid/ready handshake with stall and branch/jump redirect support. Throughput is one instruction per clock when decode never stalls.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ADDR_BITS, 12, byte-address width of instruction memory; PC upper bits are ignored for addressing
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  fetch enable; 0 parks the unit in IDLE
- pc_load  in  1  redirect request (branch/jump taken)
- pc_in  in  32  redirect target, byte address
- if_ready  in  1  decode accepts IR this cycle
- D_In  in  32  instruction word from memory D_Out (combinational read)
- im_cs  out  1  memory chip select
- im_rd  out  1  memory read strobe
- Address  out  32  byte address to memory: {zeros, PC[ADDR_BITS-1:2], 2'b00}
- IR  out  32  captured instruction
- IR_PC  out  32  PC of the instruction in IR
- PC_plus4  out  32  IR_PC + 4, for link/branch computation
- if_valid  out  1  IR holds an instruction not yet accepted
- align_err  out  1  one-cycle pulse: pc_in[1:0] != 0 on a redirect

## Operation
- Reset values: PC=RESET_PC, IR=0, IR_PC=0, if_valid=0, align_err=0, state=IDLE, im_cs=im_rd=0.
- Transfer: fires on a cycle with if_valid=1 and if_ready=1. IR is free when if_valid=0 or a transfer fires.
- States:
  - IDLE: im_cs=im_rd=0. Goes to FETCH when run=1.
  - FETCH: im_cs=im_rd=1, Address from PC.
    - If IR is free, capture IR<=D_In, IR_PC<=PC, PC<=PC+4 (mod 2^32), if_valid<=1.
    - If IR is not free, go to STALL with no capture and PC unchanged.
    - If run=0 and IR is free, go to IDLE with no capture.
  - STALL: im_rd=0, im_cs=0, PC and IR held. Returns to FETCH on the cycle a transfer fires. In that same cycle if_valid<=0, and the fetch resumes the next cycle.
  - When a transfer fires with no new capture, if_valid clears.
- Redirect (pc_load=1) has priority over everything in any state except reset:
  - PC<=pc_in with bits [1:0] forced to 00.
  - if_valid<=0, which flushes IR.
  - No capture that cycle.
  - state<=FETCH if run=1, else IDLE.
  - align_err<=1 for one cycle if pc_in[1:0]!=0.
- A redirect coinciding with a transfer: the transfer still counts (decode took IR), and the flush applies to the following slot.
- PC wraps 32'hFFFF_FFFC -> 0. Address wraps within 2^ADDR_BITS because the upper bits are masked.
- Memory is never written by this block.

## Timing
- Address and im_rd are combinational from state and PC. D_In is sampled at the same rising edge.
- Latency: PC to IR valid is 1 clock. Redirect to the first target instruction in IR is 2 clocks after pc_load is sampled.
- First instruction is valid 2 edges after reset deasserts with run=1 (IDLE->FETCH, then capture).
- Reset mid-operation asynchronously clears if_valid and returns to IDLE. No partial state survives.
- if_ready is ignored while if_valid=0.

## Structure
- Shared package: state encoding (IDLE=2'b00, FETCH=2'b01, STALL=2'b10), word increment constant 32'd4, default RESET_PC.
- Natural sub-module: pc_register (PC storage with load/increment/hold priority mux). The FSM and IR capture stay in the top module.

## Test plan
- Reset then run=1, if_ready=1, memory preloaded with 0x2008_0005 @0 and 0x2009_000A @4 -> IR=0x2008_0005/IR_PC=0 on the 2nd edge, then 0x2009_000A/IR_PC=4 on the 3rd; if_valid stays 1.
- Stall: hold if_ready=0 for 3 cycles after the first capture -> IR, IR_PC and PC frozen, im_rd=0; release gives IR_PC=4 one cycle later.
- Redirect: pc_load=1, pc_in=0x0000_0100 while fetching @8 -> if_valid=0 next cycle; IR_PC=0x100 the cycle after; the @8 instruction is never presented.
- Misaligned redirect pc_in=0x0000_0102 -> align_err pulses 1 cycle; next IR_PC=0x100.
- Wrap: RESET_PC=0x0000_0FFC, ADDR_BITS=12 -> Address=0xFFC, then Address=0x000 with IR_PC=0x1000 (PC not masked).
- Assert reset mid-stall with if_valid=1 -> if_valid=0, im_cs=0 immediately (asynchronous), PC=RESET_PC.
